hqm_list_sel_qid2cqidx_access_ctl: RTL and testbench
====================================================

Name: hqm_list_sel_qid2cqidx_access_ctl

Overview:
Sequencer and arbiter in front of the packed 512x8 (+parity) qid2cqidx RAM. The RAM has no read/write collision protection, so this block owns both of its ports. After reset it zero-initialises all 512 entries. It then shares the RAM between pipeline lookups and config reads/writes. Every write is followed by a 2-cycle lockout so the RAM's read-modify-write can finish before any other access is issued.

Parameters:
ADDR_W, 9, entry address width (512 entries)
DATA_W, 8, entry data width
STARVE_MAX, 8, consecutive ungranted cycles after which a pending cfg read beats lookups
WR_LOCK, 2, cycles after a write issue during which neither ram_re nor ram_we may be issued

Ports:
clk  in  1  single clock for the block and the RAM
rst  in  1  synchronous, active-high reset
lu_req_v  in  1  pipeline lookup request valid
lu_req_addr  in  ADDR_W  lookup qid index
lu_req_ready  out  1  lookup accepted when lu_req_v & lu_req_ready
lu_rsp_v  out  1  lookup data valid
lu_rsp_data  out  DATA_W  cq index read from the RAM
lu_rsp_perr  out  1  parity error on the lookup data
cfg_req_v  in  1  config request valid
cfg_req_wr  in  1  1 = write, 0 = read
cfg_req_addr  in  ADDR_W  config entry address
cfg_req_wdata  in  DATA_W  config write data
cfg_req_inj_perr  in  1  invert generated parity on a write (error injection)
cfg_req_ready  out  1  config request accepted when cfg_req_v & cfg_req_ready
cfg_rsp_v  out  1  config completion pulse
cfg_rsp_rdata  out  DATA_W  config read data; 0 for writes
cfg_rsp_perr  out  1  parity error on a config read
ram_we  out  1  RAM write request (starts the RAM's RMW)
ram_waddr  out  ADDR_W  RAM write address
ram_wdata  out  DATA_W  RAM write data
ram_wdata_parity  out  1  RAM write parity
ram_re  out  1  RAM read enable
ram_raddr  out  ADDR_W  RAM read address
ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_re
ram_rdata_parity  in  1  RAM read parity
init_done  out  1  high once the init sweep has completed
busy  out  1  high when state != IDLE

Behaviour:
- Reset values: all outputs 0. State = INIT, init_addr = 0, starve_cnt = 0, read tracker cleared. Reset mid-operation abandons any in-flight access; integration ties the RAM rst_n to ~rst.
- Parity is even: generated parity = ^wdata ^ cfg_req_inj_perr; read perr = ^{rdata, parity}.
- FSM states: INIT, IDLE, WR_W1, WR_W2.
- INIT:
  - Issues ram_we, waddr = init_addr, wdata = 0, parity = 0, then goes to WR_W1.
  - WR_W2 returns to INIT while init_addr < 511; init_addr then increments.
  - After the write to address 511, WR_W2 goes to IDLE and sets init_done (sticky until rst).
  - No requests are accepted during init; lu_req_ready = cfg_req_ready = 0.
- WR_W1 -> WR_W2 -> IDLE, unconditionally. Both readies are 0 and ram_re = ram_we = 0 in these states.
- IDLE arbitration, one grant per cycle, priority order:
  1. cfg write: ram_we asserted the same cycle as acceptance, next state WR_W1.
  2. cfg read with starve_cnt >= STARVE_MAX.
  3. lookup.
  4. cfg read.
- Readies are combinational from this arbitration. A cfg write present blocks lu_req_ready in that cycle.
- starve_cnt:
  - Increments in each IDLE cycle with cfg_req_v & !cfg_req_wr that is not granted (saturates).
  - Clears on a cfg read grant or rst.
  - Holds in all other cycles.
- Reads are fully pipelined, one per cycle in IDLE. ram_re and ram_raddr are driven in the grant cycle T.
- A 1-cycle tracker routes the read response at T+1 to lu_rsp_* or cfg_rsp_*. Data and perr pass combinationally from the ram_rdata and ram_rdata_parity inputs.
- Write completion: cfg_rsp_v pulses in WR_W2 of a cfg write (T+2), with cfg_rsp_rdata = 0 and perr = 0. Init writes produce no cfg_rsp_v.
- Write followed by read: a read granted in the IDLE cycle after WR_W2 (T+3) returns the newly written data.
- A read grant in cycle T-1 followed by a write in T is legal. The read response still appears at T.

Test Plan:
1. Deassert rst at cycle 0 -> ram_we pulses at cycles 0, 3, …, 1533 with waddr 0..511, wdata 0, parity 0; init_done = 1 and busy = 0 at cycle 1536; both readies 0 before cycle 1536.
2. Cfg write addr 0x105, data 0xA5 at T -> ram_we at T with parity 0; ram_re = 0 at T+1 and T+2; cfg_rsp_v at T+2. Lookup 0x105 at T+3 -> lu_rsp_v at T+4 with data 0xA5, perr 0.
3. Cfg write addr 3, data 0x01 with inj_perr = 1 -> ram_wdata_parity = 0. A later lookup of addr 3 -> lu_rsp_data 0x01, lu_rsp_perr = 1.
4. lu_req_v held high continuously, cfg read of addr 7 raised at T -> cfg_req_ready = 1 and lu_req_ready = 0 at T+8. cfg_rsp_v at T+9 carries the addr 7 data. Lookups resume at T+9.
5. Cfg write and lookup asserted together at T -> write granted; lu_req_ready = 0 at T, T+1, T+2; lookup granted at T+3.
6. Assert rst for 1 cycle at cycle 100 of init -> all outputs 0 during reset; sweep restarts at addr 0; init_done stays 0 until 1536 cycles after reset deasserts.

Source files
------------

// File: rtl/hqm_list_sel_qid2cqidx_access_ctl_if.sv
// Signal bundle between the qid2cqidx access controller, its requesters and the RAM.
// The slave side is the controller; the master side is the pipeline, config and RAM.
interface hqm_list_sel_qid2cqidx_access_ctl_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8
);
   logic              lu_req_v;
   logic [ADDR_W-1:0] lu_req_addr;
   logic              lu_req_ready;
   logic              lu_rsp_v;
   logic [DATA_W-1:0] lu_rsp_data;
   logic              lu_rsp_perr;
   logic              cfg_req_v;
   logic              cfg_req_wr;
   logic [ADDR_W-1:0] cfg_req_addr;
   logic [DATA_W-1:0] cfg_req_wdata;
   logic              cfg_req_inj_perr;
   logic              cfg_req_ready;
   logic              cfg_rsp_v;
   logic [DATA_W-1:0] cfg_rsp_rdata;
   logic              cfg_rsp_perr;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_wdata_parity;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_raddr;
   logic [DATA_W-1:0] ram_rdata;
   logic              ram_rdata_parity;
   logic              init_done;
   logic              busy;

   modport slave (
      input  lu_req_v, lu_req_addr,
      output lu_req_ready, lu_rsp_v, lu_rsp_data, lu_rsp_perr,
      input  cfg_req_v, cfg_req_wr, cfg_req_addr, cfg_req_wdata, cfg_req_inj_perr,
      output cfg_req_ready, cfg_rsp_v, cfg_rsp_rdata, cfg_rsp_perr,
      output ram_we, ram_waddr, ram_wdata, ram_wdata_parity, ram_re, ram_raddr,
      input  ram_rdata, ram_rdata_parity,
      output init_done, busy
   );

   modport master (
      output lu_req_v, lu_req_addr,
      input  lu_req_ready, lu_rsp_v, lu_rsp_data, lu_rsp_perr,
      output cfg_req_v, cfg_req_wr, cfg_req_addr, cfg_req_wdata, cfg_req_inj_perr,
      input  cfg_req_ready, cfg_rsp_v, cfg_rsp_rdata, cfg_rsp_perr,
      input  ram_we, ram_waddr, ram_wdata, ram_wdata_parity, ram_re, ram_raddr,
      output ram_rdata, ram_rdata_parity,
      input  init_done, busy
   );
endinterface

// File: rtl/hqm_list_sel_qid2cqidx_access_ctl.sv
// Owns both ports of the qid2cqidx RAM: zero-fills it after reset, then arbitrates
// lookups and config accesses, locking the RAM out for WR_LOCK cycles after each write.
module hqm_list_sel_qid2cqidx_access_ctl #(
   parameter int ADDR_W     = 9,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 8,
   parameter int WR_LOCK    = 2
) (
   input logic clk,
   input logic rst,
   hqm_list_sel_qid2cqidx_access_ctl_if.slave bus
);

   localparam logic [1:0] INIT  = 2'd0;
   localparam logic [1:0] IDLE  = 2'd1;
   localparam logic [1:0] WR_W1 = 2'd2;
   localparam logic [1:0] WR_W2 = 2'd3;

   localparam int                SC_W         = $clog2(STARVE_MAX + 1);
   localparam logic [SC_W-1:0]   STARVE_LIM   = SC_W'(STARVE_MAX);
   localparam logic [ADDR_W-1:0] ADDR_LAST    = '1;
   localparam logic [3:0]        LOCK_W1_LAST = 4'(WR_LOCK - 2);

   function automatic logic gen_parity(input logic [DATA_W-1:0] d, input logic inj);
      return (^d) ^ inj;
   endfunction

   function automatic logic chk_parity(input logic [DATA_W-1:0] d, input logic p);
      return ^{d, p};
   endfunction

   logic [1:0]        state_q, state_nxt;
   logic [ADDR_W-1:0] init_addr_q;
   logic              init_done_q;
   logic [SC_W-1:0]   starve_q;
   logic [3:0]        lock_q;
   logic              lu_vld_p1, cfg_vld_p1;

   logic idle, in_init, cfg_wr, cfg_rd, starve_hi;
   logic cfg_wr_gnt, cfg_rd_urg, cfg_rd_gnt, lu_gnt;
   logic rsp_perr, lu_rsp_on, cfg_rd_rsp_on, wr_done;

   // Grant decode; rst gates everything so all outputs read 0 while it is held.
   always_comb begin
      idle       = !rst && (state_q == IDLE);
      in_init    = !rst && (state_q == INIT);
      cfg_wr     = bus.cfg_req_v &  bus.cfg_req_wr;
      cfg_rd     = bus.cfg_req_v & !bus.cfg_req_wr;
      starve_hi  = (starve_q >= STARVE_LIM);
      cfg_wr_gnt = idle & cfg_wr;
      cfg_rd_urg = idle & cfg_rd & starve_hi;
      lu_gnt     = idle & bus.lu_req_v & !cfg_wr & !cfg_rd_urg;
      cfg_rd_gnt = cfg_rd_urg | (idle & cfg_rd & !bus.lu_req_v);
   end

   assign bus.lu_req_ready  = idle & !cfg_wr & !(cfg_rd & starve_hi);
   assign bus.cfg_req_ready = idle & (bus.cfg_req_wr | starve_hi | !bus.lu_req_v);

   assign bus.ram_we           = in_init | cfg_wr_gnt;
   assign bus.ram_waddr        = in_init ? init_addr_q :
                                 (cfg_wr_gnt ? bus.cfg_req_addr : '0);
   assign bus.ram_wdata        = cfg_wr_gnt ? bus.cfg_req_wdata : '0;
   assign bus.ram_wdata_parity = cfg_wr_gnt & gen_parity(bus.cfg_req_wdata, bus.cfg_req_inj_perr);
   assign bus.ram_re           = lu_gnt | cfg_rd_gnt;
   assign bus.ram_raddr        = lu_gnt     ? bus.lu_req_addr  :
                                 cfg_rd_gnt ? bus.cfg_req_addr : '0;

   // Read responses arrive one cycle after the grant and are steered by the tracker.
   assign rsp_perr      = chk_parity(bus.ram_rdata, bus.ram_rdata_parity);
   assign lu_rsp_on     = !rst & lu_vld_p1;
   assign cfg_rd_rsp_on = !rst & cfg_vld_p1;
   assign wr_done       = !rst && (state_q == WR_W2) && init_done_q;

   assign bus.lu_rsp_v      = lu_rsp_on;
   assign bus.lu_rsp_data   = lu_rsp_on ? bus.ram_rdata : '0;
   assign bus.lu_rsp_perr   = lu_rsp_on & rsp_perr;
   assign bus.cfg_rsp_v     = cfg_rd_rsp_on | wr_done;
   assign bus.cfg_rsp_rdata = cfg_rd_rsp_on ? bus.ram_rdata : '0;
   assign bus.cfg_rsp_perr  = cfg_rd_rsp_on & rsp_perr;

   assign bus.init_done = !rst & init_done_q;
   assign bus.busy      = !rst && (state_q != IDLE);

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         INIT:    state_nxt = WR_W1;
         IDLE:    if (cfg_wr_gnt) state_nxt = WR_W1;
         WR_W1:   if (lock_q >= LOCK_W1_LAST) state_nxt = WR_W2;
         default: state_nxt = (init_done_q || (init_addr_q == ADDR_LAST)) ? IDLE : INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= INIT;
         init_addr_q <= '0;
         init_done_q <= 1'b0;
         starve_q    <= '0;
         lock_q      <= '0;
         lu_vld_p1   <= 1'b0;
         cfg_vld_p1  <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         lu_vld_p1  <= lu_gnt;
         cfg_vld_p1 <= cfg_rd_gnt;
         lock_q     <= ((state_q == WR_W1) && (state_nxt == WR_W1)) ? lock_q + 4'd1 : 4'd0;
         if ((state_q == WR_W2) && !init_done_q) begin
            if (init_addr_q == ADDR_LAST) init_done_q <= 1'b1;
            else                          init_addr_q <= init_addr_q + 1'b1;
         end
         // A pending read that loses arbitration ages until it gets priority.
         if (cfg_rd_gnt)
            starve_q <= '0;
         else if (idle && cfg_rd && !starve_hi)
            starve_q <= starve_q + SC_W'(1);
      end
   end

endmodule

// File: tb/tb_hqm_list_sel_qid2cqidx_access_ctl.sv
// Directed bench for the qid2cqidx access controller with a behavioural 512x9 RAM.
module tb_hqm_list_sel_qid2cqidx_access_ctl;

   logic clk;
   logic rst;
   int   check_cnt = 0;
   int   pass_cnt  = 0;

   hqm_list_sel_qid2cqidx_access_ctl_if #(.ADDR_W(9), .DATA_W(8)) bus_if ();

   hqm_list_sel_qid2cqidx_access_ctl #(
      .ADDR_W(9), .DATA_W(8), .STARVE_MAX(8), .WR_LOCK(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: write lands at the edge, read data is registered one cycle after ram_re
   logic [8:0] mem [512];
   always @(posedge clk) begin
      if (bus_if.ram_we) mem[bus_if.ram_waddr] <= {bus_if.ram_wdata_parity, bus_if.ram_wdata};
      if (bus_if.ram_re) {bus_if.ram_rdata_parity, bus_if.ram_rdata} <= mem[bus_if.ram_raddr];
   end

   logic [52:0] all_outs;
   assign all_outs = {bus_if.lu_req_ready, bus_if.lu_rsp_v, bus_if.lu_rsp_data, bus_if.lu_rsp_perr,
                      bus_if.cfg_req_ready, bus_if.cfg_rsp_v, bus_if.cfg_rsp_rdata, bus_if.cfg_rsp_perr,
                      bus_if.ram_we, bus_if.ram_waddr, bus_if.ram_wdata, bus_if.ram_wdata_parity,
                      bus_if.ram_re, bus_if.ram_raddr, bus_if.init_done, bus_if.busy};

   logic [23:0] sweep_vec;
   assign sweep_vec = {bus_if.ram_we, bus_if.ram_waddr, bus_if.ram_wdata, bus_if.ram_wdata_parity,
                       bus_if.ram_re, bus_if.lu_req_ready, bus_if.cfg_req_ready,
                       bus_if.init_done, bus_if.busy};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic sweep(input int ncyc);
      logic [23:0] exp;
      for (int c = 0; c < ncyc; c++) begin
         exp = {(c % 3 == 0), ((c % 3 == 0) ? 9'(c / 3) : 9'd0), 8'h00, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
         chk("init_sweep", sweep_vec, exp);
         step();
         settle();
      end
   endtask

   // Drives a cfg write in cycle T, checks T..T+2, returns settled in T+3 with inputs idle.
   task automatic cfg_write(input logic [8:0] a, input logic [7:0] d, input logic inj,
                            input logic exp_par);
      bus_if.cfg_req_v = 1'b1;  bus_if.cfg_req_wr = 1'b1;
      bus_if.cfg_req_addr = a;  bus_if.cfg_req_wdata = d;  bus_if.cfg_req_inj_perr = inj;
      settle();
      chk("wr_accept", {bus_if.cfg_req_ready, bus_if.ram_we, bus_if.ram_waddr, bus_if.ram_wdata},
          {1'b1, 1'b1, a, d});
      chk("wr_parity", bus_if.ram_wdata_parity, exp_par);
      step();
      bus_if.cfg_req_v = 1'b0;  bus_if.cfg_req_wr = 1'b0;  bus_if.cfg_req_inj_perr = 1'b0;
      settle();
      chk("wr_lock1", {bus_if.ram_re, bus_if.ram_we, bus_if.cfg_rsp_v, bus_if.busy}, 4'b0001);
      step();
      settle();
      chk("wr_lock2", {bus_if.ram_re, bus_if.ram_we, bus_if.busy}, 3'b001);
      chk("wr_done", {bus_if.cfg_rsp_v, bus_if.cfg_rsp_rdata, bus_if.cfg_rsp_perr}, {1'b1, 8'h00, 1'b0});
      step();
      settle();
   endtask

   initial begin
      rst = 1'b1;
      bus_if.lu_req_v = 1'b0;      bus_if.lu_req_addr = '0;
      bus_if.cfg_req_v = 1'b0;     bus_if.cfg_req_wr = 1'b0;
      bus_if.cfg_req_addr = '0;    bus_if.cfg_req_wdata = '0;
      bus_if.cfg_req_inj_perr = 1'b0;

      step();
      step();
      settle();
      chk("reset_outs", all_outs, 53'd0);

      // Start init, interrupt it with a one-cycle reset at cycle 100, then run the full sweep
      step();
      rst = 1'b0;
      settle();
      sweep(100);
      rst = 1'b1;
      settle();
      chk("midinit_reset_outs", all_outs, 53'd0);
      step();
      rst = 1'b0;
      settle();
      sweep(1536);
      chk("init_done_idle", {bus_if.init_done, bus_if.busy, bus_if.lu_req_ready, bus_if.cfg_req_ready},
          4'b1011);

      // Write 0x105 = 0xA5, then look it up immediately after the lockout
      cfg_write(9'h105, 8'hA5, 1'b0, 1'b0);
      bus_if.lu_req_v = 1'b1;  bus_if.lu_req_addr = 9'h105;
      settle();
      chk("lu_after_wr_grant", {bus_if.lu_req_ready, bus_if.ram_re, bus_if.ram_raddr}, {2'b11, 9'h105});
      step();
      bus_if.lu_req_v = 1'b0;
      settle();
      chk("lu_after_wr_rsp", {bus_if.lu_rsp_v, bus_if.lu_rsp_data, bus_if.lu_rsp_perr, bus_if.cfg_rsp_v},
          {1'b1, 8'hA5, 1'b0, 1'b0});

      // Parity injection: 0x01 with inverted parity reads back as a parity error
      cfg_write(9'h003, 8'h01, 1'b1, 1'b0);
      bus_if.lu_req_v = 1'b1;  bus_if.lu_req_addr = 9'h003;
      settle();
      step();
      bus_if.lu_req_v = 1'b0;
      settle();
      chk("lu_inj_perr", {bus_if.lu_rsp_v, bus_if.lu_rsp_data, bus_if.lu_rsp_perr}, {1'b1, 8'h01, 1'b1});

      // Starvation: continuous lookups hold off a cfg read for 8 cycles
      cfg_write(9'h007, 8'h3C, 1'b0, 1'b0);
      bus_if.lu_req_v = 1'b1;   bus_if.lu_req_addr = 9'h105;
      bus_if.cfg_req_v = 1'b1;  bus_if.cfg_req_wr = 1'b0;  bus_if.cfg_req_addr = 9'h007;
      settle();
      for (int k = 0; k < 8; k++) begin
         chk("starve_wait", {bus_if.cfg_req_ready, bus_if.lu_req_ready}, 2'b01);
         step();
         settle();
      end
      chk("starve_grant", {bus_if.cfg_req_ready, bus_if.lu_req_ready, bus_if.ram_re, bus_if.ram_raddr},
          {3'b101, 9'h007});
      chk("starve_lu_rsp", {bus_if.lu_rsp_v, bus_if.lu_rsp_data}, {1'b1, 8'hA5});
      step();
      bus_if.cfg_req_v = 1'b0;
      settle();
      chk("starve_cfg_rsp", {bus_if.cfg_rsp_v, bus_if.cfg_rsp_rdata, bus_if.cfg_rsp_perr, bus_if.lu_rsp_v},
          {1'b1, 8'h3C, 1'b0, 1'b0});
      chk("lu_resume", {bus_if.lu_req_ready, bus_if.ram_re, bus_if.ram_raddr}, {2'b11, 9'h105});
      step();
      bus_if.cfg_req_v = 1'b1;
      settle();
      chk("lu_resume_rsp", {bus_if.lu_rsp_v, bus_if.lu_rsp_data}, {1'b1, 8'hA5});
      chk("starve_cleared", bus_if.cfg_req_ready, 1'b0);
      step();
      bus_if.cfg_req_v = 1'b0;
      bus_if.lu_req_v = 1'b0;
      settle();
      step();
      settle();

      // Write and lookup together at the top address: write wins, lookup waits out the lockout
      bus_if.cfg_req_v = 1'b1;  bus_if.cfg_req_wr = 1'b1;
      bus_if.cfg_req_addr = 9'h1FF;  bus_if.cfg_req_wdata = 8'h80;
      bus_if.lu_req_v = 1'b1;   bus_if.lu_req_addr = 9'h1FF;
      settle();
      chk("wr_vs_lu_t0", {bus_if.cfg_req_ready, bus_if.lu_req_ready, bus_if.ram_we, bus_if.ram_re,
                          bus_if.ram_wdata_parity}, 5'b10101);
      step();
      bus_if.cfg_req_v = 1'b0;  bus_if.cfg_req_wr = 1'b0;
      settle();
      chk("wr_vs_lu_t1", bus_if.lu_req_ready, 1'b0);
      step();
      settle();
      chk("wr_vs_lu_t2", {bus_if.lu_req_ready, bus_if.cfg_rsp_v}, 2'b01);
      step();
      settle();
      chk("wr_vs_lu_t3", {bus_if.lu_req_ready, bus_if.ram_re, bus_if.ram_raddr}, {2'b11, 9'h1FF});
      step();
      bus_if.lu_req_v = 1'b0;
      settle();
      chk("wr_vs_lu_rsp", {bus_if.lu_rsp_v, bus_if.lu_rsp_data, bus_if.lu_rsp_perr}, {1'b1, 8'h80, 1'b0});

      // Lookup in T-1 then cfg write in T: the read response still lands in T
      bus_if.lu_req_v = 1'b1;  bus_if.lu_req_addr = 9'h003;
      settle();
      step();
      bus_if.lu_req_v = 1'b0;
      bus_if.cfg_req_v = 1'b1;  bus_if.cfg_req_wr = 1'b1;
      bus_if.cfg_req_addr = 9'h005;  bus_if.cfg_req_wdata = 8'h11;
      settle();
      chk("rd_then_wr", {bus_if.lu_rsp_v, bus_if.lu_rsp_data, bus_if.lu_rsp_perr,
                         bus_if.cfg_req_ready, bus_if.ram_we}, {1'b1, 8'h01, 1'b1, 2'b11});
      step();
      bus_if.cfg_req_v = 1'b0;  bus_if.cfg_req_wr = 1'b0;
      settle();
      step();
      settle();
      step();
      settle();

      // Plain cfg read with no competing lookup
      bus_if.cfg_req_v = 1'b1;  bus_if.cfg_req_addr = 9'h005;
      settle();
      chk("cfg_rd_grant", {bus_if.cfg_req_ready, bus_if.ram_re, bus_if.ram_raddr}, {2'b11, 9'h005});
      step();
      bus_if.cfg_req_v = 1'b0;
      settle();
      chk("cfg_rd_rsp", {bus_if.cfg_rsp_v, bus_if.cfg_rsp_rdata, bus_if.cfg_rsp_perr}, {1'b1, 8'h11, 1'b0});

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
